// File: rtl/bram_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bram_read_scheduler
//  Description : Shares one read-only parameter BRAM between N_CLIENTS loader
//                clients. Clients are served one at a time in round-robin
//                order. The scheduler issues one read per cycle, absorbs the
//                fixed BRAM read latency, and returns each word tagged with
//                the client id and the word index. It then pulses the
//                client's done.
//  Ports       : clk, rst_n          - clock, asynchronous active-low reset
//                i_req/i_req_base/i_req_len - per-client level request,
//                                      base address and word count
//                o_grant             - one-hot owner of the current transfer
//                o_bram_en/o_bram_ren/o_bram_addr, i_bram_dout - BRAM port
//                o_rd_valid/o_rd_data/o_rd_id/o_rd_index - returned words
//                o_done              - one-cycle pulse per completed client
//                o_busy              - scheduler not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_read_scheduler #(
    parameter int N_CLIENTS  = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_W      = 18,
    parameter int W          = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CLIENTS-1:0]           i_req,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0] i_req_base,
    input  logic [N_CLIENTS*LEN_W-1:0]     i_req_len,
    output logic [N_CLIENTS-1:0]           o_grant,
    output logic                           o_bram_en,
    output logic                           o_bram_ren,
    output logic [ADDR_WIDTH-1:0]          o_bram_addr,
    input  logic [W-1:0]                   i_bram_dout,
    output logic                           o_rd_valid,
    output logic [W-1:0]                   o_rd_data,
    output logic [$clog2(N_CLIENTS)-1:0]   o_rd_id,
    output logic [LEN_W-1:0]               o_rd_index,
    output logic [N_CLIENTS-1:0]           o_done,
    output logic                           o_busy
);

    localparam int ID_W = $clog2(N_CLIENTS);

    localparam logic [LEN_W:0]         c_ONE_LEN   = 1;
    localparam logic [ADDR_WIDTH-1:0]  c_ONE_ADDR  = 1;
    localparam logic [ID_W-1:0]        c_ONE_ID    = 1;
    localparam logic [N_CLIENTS-1:0]   c_ONE_GRANT = 1;
    localparam logic [ID_W-1:0]        c_LAST_ID   = ID_W'(N_CLIENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_owner;
    // Counters are one bit wider than the length field so that a length of
    // 2^LEN_W-1 can be counted up to without wrapping.
    logic [LEN_W:0]         r_len;
    logic [LEN_W:0]         r_iss_cnt;
    logic [LEN_W:0]         r_ret_cnt;
    // One bit per cycle of BRAM latency; the top bit marks a valid bram_dout.
    logic [RD_LAT-1:0]      r_pipe;
    logic [N_CLIENTS-1:0]   r_grant;
    logic [N_CLIENTS-1:0]   r_done;
    logic                   r_en;
    logic                   r_ren;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_rd_valid;
    logic [W-1:0]           r_rd_data;
    logic [ID_W-1:0]        r_rd_id;
    logic [LEN_W-1:0]       r_rd_index;

    logic                   w_found;
    logic [ID_W-1:0]        w_win;
    logic [ID_W-1:0]        w_scan_idx;
    logic [ADDR_WIDTH-1:0]  w_win_base;
    logic [LEN_W-1:0]       w_win_len;
    logic [ID_W-1:0]        w_next_ptr;

    // Round-robin scan: the first requester at or after r_rr_ptr, with
    // wrap-around, wins.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_scan_idx = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_scan_idx = ID_W'((int'(r_rr_ptr) + i) % N_CLIENTS);
            if (!w_found && i_req[w_scan_idx]) begin
                w_found = 1'b1;
                w_win   = w_scan_idx;
            end
        end
    end

    assign w_win_base = i_req_base[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_len  = i_req_len[int'(w_win)*LEN_W +: LEN_W];
    assign w_next_ptr = (r_owner == c_LAST_ID) ? '0 : r_owner + c_ONE_ID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_len      <= '0;
            r_iss_cnt  <= '0;
            r_ret_cnt  <= '0;
            r_pipe     <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_en       <= 1'b0;
            r_ren      <= 1'b0;
            r_addr     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_id    <= '0;
            r_rd_index <= '0;
        end else begin
            // Return path. The word for an address is on bram_dout when the
            // matching token reaches the top of r_pipe. It is registered on
            // the following edge.
            r_pipe[0] <= r_ren;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_rd_valid <= r_pipe[RD_LAT-1];
            if (r_pipe[RD_LAT-1]) begin
                r_rd_data  <= i_bram_dout;
                r_rd_index <= r_ret_cnt[LEN_W-1:0];
                r_rd_id    <= r_owner;
                r_ret_cnt  <= r_ret_cnt + c_ONE_LEN;
            end

            r_done <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_win;
                        r_grant   <= c_ONE_GRANT << w_win;
                        r_addr    <= w_win_base;
                        r_len     <= {1'b0, w_win_len};
                        r_iss_cnt <= c_ONE_LEN;
                        r_ret_cnt <= '0;
                        // A zero-length request holds grant for one cycle
                        // but never touches the BRAM.
                        r_en      <= (w_win_len != '0);
                        r_ren     <= (w_win_len != '0);
                        r_state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (r_len == '0) begin
                        r_done   <= r_grant;
                        r_grant  <= '0;
                        r_en     <= 1'b0;
                        r_ren    <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_FINISH;
                    end else if (r_iss_cnt == r_len) begin
                        // Last address is on the bus this cycle. Keep the
                        // BRAM enabled while the outstanding words drain.
                        r_ren   <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr    <= r_addr + c_ONE_ADDR;
                        r_iss_cnt <= r_iss_cnt + c_ONE_LEN;
                    end
                end

                S_DRAIN: begin
                    // The last word is on rd_data this cycle. Done lands on
                    // the following cycle.
                    if (r_rd_valid && (r_ret_cnt == r_len)) begin
                        r_done   <= r_grant;
                        r_grant  <= '0;
                        r_en     <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_bram_en   = r_en;
    assign o_bram_ren  = r_ren;
    assign o_bram_addr = r_addr;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_rd_id     = r_rd_id;
    assign o_rd_index  = r_rd_index;
    assign o_done      = r_done;
    assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
